// File: rtl/alarm_gate_pkg.sv
// Shared constants, FSM encodings and a width helper for the alarm event aggregator.
package alarm_gate_pkg;

    localparam int REDUCE_AND = 0;
    localparam int REDUCE_OR  = 1;
    localparam int REDUCE_XOR = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ACKED  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit plus a valid flag.
module lowest_set_index #(
    parameter int NUM_INPUTS = 10,
    parameter int SRC_W      = 4
) (
    input  logic [NUM_INPUTS-1:0] vec,
    output logic [SRC_W-1:0]      index,
    output logic                  valid
);

    // Scanning from the top down lets the lowest set bit overwrite the others.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = SRC_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_event_aggregator.sv
// Registered N-input masked reduction with sticky alarm latch, rise pulse,
// per-channel pending capture, first-source index and acknowledge/re-arm FSM.
module alarm_event_aggregator
    import alarm_gate_pkg::*;
#(
    parameter int                  NUM_INPUTS   = 10,
    parameter logic [NUM_INPUTS-1:0] BUBBLES_MASK = '0,
    parameter int                  REDUCE_MODE  = 1,
    parameter int                  STICKY       = 1,
    localparam int                 SRC_W        = clog2((NUM_INPUTS > 2) ? NUM_INPUTS : 2)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  tick_en,
    input  logic [NUM_INPUTS-1:0] inputs,
    input  logic                  clear,
    output logic                  result,
    output logic                  rise_pulse,
    output logic                  alarm_out,
    output logic [NUM_INPUTS-1:0] pending,
    output logic [SRC_W-1:0]      first_src,
    output logic [1:0]            state_dbg
);

    logic [NUM_INPUTS-1:0] in_q;
    logic                  reduced;
    logic                  result_prev;
    logic [SRC_W-1:0]      lsi_index;
    logic                  lsi_valid;
    state_t                state;

    always_comb begin
        case (REDUCE_MODE)
            REDUCE_AND: reduced = &in_q;
            REDUCE_XOR: reduced = ^in_q;
            default:    reduced = |in_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q   <= '0;
            result <= 1'b0;
        end else if (tick_en) begin
            in_q   <= inputs ^ BUBBLES_MASK;
            result <= reduced;
        end
    end

    // Edge detector runs on every clock so the pulse is one clock wide even with tick_en low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) result_prev <= 1'b0;
        else          result_prev <= result;
    end

    assign rise_pulse = result & ~result_prev;

    lowest_set_index #(
        .NUM_INPUTS (NUM_INPUTS),
        .SRC_W      (SRC_W)
    ) u_lsi (
        .vec   (in_q),
        .index (lsi_index),
        .valid (lsi_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            alarm_out <= 1'b0;
            pending   <= '0;
            first_src <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_pulse) begin
                        state     <= ACTIVE;
                        alarm_out <= 1'b1;
                        first_src <= lsi_valid ? lsi_index : '0;
                        pending   <= in_q;
                    end
                end
                ACTIVE: begin
                    if (clear) begin
                        pending   <= '0;
                        alarm_out <= 1'b0;
                        state     <= result ? ACKED : IDLE;
                    end else begin
                        if (tick_en) pending <= pending | in_q;
                        if (STICKY == 0 && !result) begin
                            state     <= IDLE;
                            alarm_out <= 1'b0;
                        end
                    end
                end
                ACKED: begin
                    pending <= '0;
                    if (!result) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    alarm_out <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_alarm_event_aggregator.sv
// Directed bench for alarm_event_aggregator: cycle table for the main instance,
// hand-written sequences for reset, bubble mask, AND mode and non-sticky exit.
module tb_alarm_event_aggregator;

    logic clock = 1'b0;
    logic reset_n;
    logic tick_en;
    logic clear;
    logic [9:0] in0, in_a, in_b, in_c;

    logic       r0, p0, a0;
    logic [9:0] pend0;
    logic [3:0] f0;
    logic [1:0] s0;
    logic       r1, p1, a1;
    logic [9:0] pend1;
    logic [3:0] f1;
    logic [1:0] s1;
    logic       r2, p2, a2;
    logic [9:0] pend2;
    logic [3:0] f2;
    logic [1:0] s2;
    logic       r3, p3, a3;
    logic [9:0] pend3;
    logic [3:0] f3;
    logic [1:0] s3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    alarm_event_aggregator #(.NUM_INPUTS(10), .BUBBLES_MASK(10'h000), .REDUCE_MODE(1), .STICKY(1)) u0 (
        .clock(clock), .reset_n(reset_n), .tick_en(tick_en), .inputs(in0), .clear(clear),
        .result(r0), .rise_pulse(p0), .alarm_out(a0), .pending(pend0), .first_src(f0), .state_dbg(s0));

    alarm_event_aggregator #(.NUM_INPUTS(10), .BUBBLES_MASK(10'h001), .REDUCE_MODE(1), .STICKY(1)) u1 (
        .clock(clock), .reset_n(reset_n), .tick_en(tick_en), .inputs(in_a), .clear(clear),
        .result(r1), .rise_pulse(p1), .alarm_out(a1), .pending(pend1), .first_src(f1), .state_dbg(s1));

    alarm_event_aggregator #(.NUM_INPUTS(10), .BUBBLES_MASK(10'h001), .REDUCE_MODE(0), .STICKY(1)) u2 (
        .clock(clock), .reset_n(reset_n), .tick_en(tick_en), .inputs(in_b), .clear(clear),
        .result(r2), .rise_pulse(p2), .alarm_out(a2), .pending(pend2), .first_src(f2), .state_dbg(s2));

    alarm_event_aggregator #(.NUM_INPUTS(10), .BUBBLES_MASK(10'h000), .REDUCE_MODE(1), .STICKY(0)) u3 (
        .clock(clock), .reset_n(reset_n), .tick_en(tick_en), .inputs(in_c), .clear(clear),
        .result(r3), .rise_pulse(p3), .alarm_out(a3), .pending(pend3), .first_src(f3), .state_dbg(s3));

    typedef struct {
        logic [9:0] in;
        logic       te;
        logic       clr;
        logic       res;
        logic       rise;
        logic       alarm;
        logic [1:0] st;
        logic [9:0] pend;
        logic [3:0] first;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [9:0] in, input logic te, input logic clr, input logic res,
                       input logic rise, input logic alarm, input logic [1:0] st,
                       input logic [9:0] pend, input logic [3:0] first);
        vec_t v;
        v.in = in; v.te = te; v.clr = clr; v.res = res; v.rise = rise;
        v.alarm = alarm; v.st = st; v.pend = pend; v.first = first;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        tick_en = 1'b1;
        clear   = 1'b0;
        in0     = 10'h000;
        in_a    = 10'h000;
        in_b    = 10'h3FE;
        in_c    = 10'h000;

        // in, te, clr | result, rise, alarm, state, pending, first_src
        for (int i = 0; i < 5; i++)
            add(10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd0);
        add(10'h028, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd0);
        add(10'h028, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 10'h000, 4'd0);
        add(10'h028, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 10'h028, 4'd3);
        add(10'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 10'h028, 4'd3);
        add(10'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 10'h228, 4'd3);
        add(10'h200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 10'h000, 4'd3);
        add(10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 10'h000, 4'd3);
        add(10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 10'h000, 4'd3);
        add(10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd3);
        add(10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd3);
        add(10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd3);
        add(10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd3);
        add(10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd3);
        add(10'h3FF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 10'h000, 4'd3);
        add(10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 10'h3FF, 4'd0);
        add(10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 10'h3FF, 4'd0);
        add(10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 10'h3FF, 4'd0);
        add(10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd0);
        add(10'h001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd0);
        add(10'h001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 10'h000, 4'd0);
        add(10'h001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 10'h001, 4'd0);
        add(10'h002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 10'h001, 4'd0);
        add(10'h002, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 10'h000, 4'd0);
        add(10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 10'h000, 4'd0);
        add(10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 10'h000, 4'd0);
        add(10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 4'd0);

        repeat (2) @(posedge clock);
        #1;
        check("reset result", 16'(r0), 16'h0);
        check("reset alarm", 16'(a0), 16'h0);
        check("reset state", 16'(s0), 16'h0);
        check("reset pending", 16'(pend0), 16'h0);
        check("reset first_src", 16'(f0), 16'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            in0     = vecs[i].in;
            tick_en = vecs[i].te;
            clear   = vecs[i].clr;
            @(posedge clock);
            #1;
            check($sformatf("row%0d result", i), 16'(r0), 16'(vecs[i].res));
            check($sformatf("row%0d rise_pulse", i), 16'(p0), 16'(vecs[i].rise));
            check($sformatf("row%0d alarm_out", i), 16'(a0), 16'(vecs[i].alarm));
            check($sformatf("row%0d state", i), 16'(s0), 16'(vecs[i].st));
            check($sformatf("row%0d pending", i), 16'(pend0), 16'(vecs[i].pend));
            check($sformatf("row%0d first_src", i), 16'(f0), 16'(vecs[i].first));
        end

        // Enter ACTIVE on channel 7, then drop reset between clock edges.
        @(negedge clock);
        clear   = 1'b0;
        tick_en = 1'b1;
        in0     = 10'h080;
        repeat (3) @(posedge clock);
        #1;
        check("pre-reset alarm", 16'(a0), 16'h1);
        check("pre-reset first_src", 16'(f0), 16'h7);
        check("pre-reset pending", 16'(pend0), 16'h080);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset result", 16'(r0), 16'h0);
        check("async reset rise", 16'(p0), 16'h0);
        check("async reset alarm", 16'(a0), 16'h0);
        check("async reset pending", 16'(pend0), 16'h0);
        check("async reset first_src", 16'(f0), 16'h0);
        check("async reset state", 16'(s0), 16'h0);
        check("async reset u1 alarm", 16'(a1), 16'h0);
        check("async reset u3 pending", 16'(pend3), 16'h0);

        in0  = 10'h000;
        in_a = 10'h000;
        in_b = 10'h3FE;
        in_c = 10'h010;
        @(negedge clock);
        reset_n = 1'b1;

        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("post-reset k%0d u0 rise", k), 16'(p0), 16'h0);
            check($sformatf("post-reset k%0d u0 state", k), 16'(s0), 16'h0);
            if (k == 2) begin
                check("bubble u1 result", 16'(r1), 16'h1);
                check("bubble u1 rise", 16'(p1), 16'h1);
                check("and u2 result", 16'(r2), 16'h1);
                check("and u2 rise", 16'(p2), 16'h1);
                check("nonsticky u3 rise", 16'(p3), 16'h1);
            end
            if (k == 3) begin
                check("bubble u1 alarm", 16'(a1), 16'h1);
                check("bubble u1 first_src", 16'(f1), 16'h0);
                check("bubble u1 pending", 16'(pend1), 16'h001);
                check("bubble u1 state", 16'(s1), 16'h1);
                check("and u2 alarm", 16'(a2), 16'h1);
                check("and u2 first_src", 16'(f2), 16'h0);
                check("and u2 pending", 16'(pend2), 16'h3FF);
                check("and u2 state", 16'(s2), 16'h1);
                check("nonsticky u3 alarm", 16'(a3), 16'h1);
                check("nonsticky u3 first_src", 16'(f3), 16'h4);
                check("nonsticky u3 pending", 16'(pend3), 16'h010);
                in_c = 10'h000;
            end
            if (k == 5) begin
                check("nonsticky u3 result low", 16'(r3), 16'h0);
                check("nonsticky u3 still active", 16'(s3), 16'h1);
                check("nonsticky u3 alarm held", 16'(a3), 16'h1);
            end
            if (k == 6) begin
                check("nonsticky u3 exit state", 16'(s3), 16'h0);
                check("nonsticky u3 exit alarm", 16'(a3), 16'h0);
                check("nonsticky u3 pending kept", 16'(pend3), 16'h010);
                check("nonsticky u3 first_src kept", 16'(f3), 16'h4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_event_aggregator.md
Name: alarm_event_aggregator

Overview:
- Parametrised, registered N-input reduction gate with per-input inversion ("bubble") mask and selectable AND/OR/XOR reduction.
- Feeds the alarm controller, where it replaces fixed-width combinational OR gates.
- Adds a sticky alarm latch, a one-cycle rise pulse, per-channel pending capture, a first-source index and acknowledge/re-arm handling.

Parameters:
NUM_INPUTS, 10, number of input channels; legal 1..64.
BUBBLES_MASK, 0 (NUM_INPUTS bits), bit i = 1 inverts inputs[i] before reduction.
REDUCE_MODE, 1, 0 = AND, 1 = OR, 2 = XOR; value 3 behaves as OR.
STICKY, 1, 1 = alarm held until clear; 0 = alarm follows the reduced result.
SRC_W, clog2(max(NUM_INPUTS,2)), width of first_src (derived, not overridden).

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
tick_en  in  1  clock enable for the sampling/reduction pipeline
inputs  in  NUM_INPUTS  raw event inputs, already synchronous to clock
clear  in  1  alarm acknowledge, single-cycle pulse
result  out  1  registered reduction of masked inputs
rise_pulse  out  1  one-clock pulse on result 0->1
alarm_out  out  1  latched alarm
pending  out  NUM_INPUTS  channels seen active since last clear/IDLE
first_src  out  SRC_W  lowest-index active channel at alarm entry
state_dbg  out  2  FSM state encoding

Behaviour:
- Reset (reset_n low, asynchronous):
  - all registers 0, state IDLE.
  - result, rise_pulse, alarm_out, pending, first_src all 0.
- Input stage:
  - on a clock edge with tick_en=1: in_q <= inputs ^ BUBBLES_MASK.
  - with tick_en=0, in_q holds.
- Reduction stage:
  - on a clock edge with tick_en=1: result <= reduce(in_q).
  - AND = &in_q, OR = |in_q, XOR = ^in_q.
  - Latency: an input change appears on result 2 enabled edges later.
- Rise pulse:
  - result_prev is updated every clock from result.
  - rise_pulse = result & ~result_prev, so it is high for exactly one clock per rising transition, independent of tick_en.
- FSM states: IDLE=0, ACTIVE=1, ACKED=2.
  - IDLE:
    - on rise_pulse -> ACTIVE.
    - first_src <= lowest set index of in_q; 0 if none.
    - pending <= in_q.
  - ACTIVE:
    - alarm_out=1; pending |= in_q on each enabled edge.
    - clear=1: pending <= 0; if result=1 -> ACKED, else -> IDLE.
    - STICKY=0 and result=0 with no clear -> IDLE; pending retained until next entry.
  - ACKED:
    - alarm_out=0; pending held at 0.
    - -> IDLE on the first clock with result=0.
    - rise_pulse is ignored, so no re-trigger until result has deasserted.
- alarm_out is a registered output: it is 1 exactly while state=ACTIVE.
- Simultaneous events:
  - clear and rise_pulse in IDLE: enter ACTIVE (clear is ignored in IDLE).
  - clear and pending update in ACTIVE: clear wins, pending = 0.
- clear is processed on every clock regardless of tick_en; in IDLE and ACKED it has no effect.
- tick_en=0 freezes in_q and result. The FSM still advances on clear and on the result level.
- first_src changes only on IDLE->ACTIVE entry and holds until the next entry.
- Reset mid-ACTIVE: immediate return to IDLE with all outputs 0; no pulse after reset release unless result rises again.
- NUM_INPUTS=1: SRC_W=1 and first_src is always 0.

Decomposition:
- Package alarm_gate_pkg holds:
  - REDUCE_AND/OR/XOR constants.
  - FSM state encodings IDLE/ACTIVE/ACKED.
  - a clog2 helper function.
- One sub-module: lowest_set_index (parametrised combinational priority encoder, NUM_INPUTS -> SRC_W plus a valid bit), used for first_src.

Test Plan (N=10, OR, BUBBLES_MASK=0, STICKY=1, tick_en=1 unless stated):
1. Reset then inputs=10'h000 for 5 clocks -> result=0, alarm_out=0, state_dbg=0, rise_pulse never high.
2. inputs=10'h028 at edge k -> result=1 at edge k+2; rise_pulse high for one clock; alarm_out=1; first_src=3; pending=10'h028.
3. In ACTIVE, inputs=10'h200 for 2 clocks -> pending=10'h228 and first_src stays 3. Then clear while result=1 -> state ACKED, alarm_out=0, pending=0. Then inputs=0 -> IDLE two clocks later.
4. BUBBLES_MASK=10'h001, inputs=10'h000 -> result=1 and alarm fires with first_src=0. Repeat with REDUCE_MODE=0 and inputs=10'h3FE -> result=1.
5. tick_en=0 while inputs toggle 10'h000/10'h3FF -> result frozen. Raising tick_en resumes sampling with 2-edge latency.
6. reset_n low mid-ACTIVE -> all outputs 0 asynchronously. With STICKY=0: result fall exits ACTIVE to IDLE without clear.
